// File: rtl/wb_cmd_pkg.sv
// Shared definitions for the Wishbone command master and its helpers.
package wb_cmd_pkg;

    // Master sequencing: wait for a command, run one bus cycle, hold the response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Every access is a full 32-bit word.
    localparam logic [3:0] WB_SEL_ALL = 4'hf;

    // Width needed for a cycle counter that must be able to hold the value TIMEOUT.
    function automatic int timer_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_cmd_timer.sv
// Clear/enable saturating cycle counter with a terminal-count flag.
// tc is asserted during the enabled cycle that brings the count up to MAX.
// The owner can then act on the same clock edge that completes the MAX-th cycle.
module wb_cmd_timer #(
    parameter int MAX = 255,
    parameter int W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [W-1:0] TOP  = W'(MAX);
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] count_reg;

    // Count enabled cycles, stopping at MAX rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en && (count_reg != TOP)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign tc = en && (count_reg >= LAST);

endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone classic master.
// It turns a valid/ready command stream into one bus cycle at a time.
// Each cycle returns a valid/ready response carrying read data and a timeout flag.
module wb_cmd_master
    import wb_cmd_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i
);

    localparam int TW = timer_width(TIMEOUT);

    state_t state_reg;
    logic   timer_clr;
    logic   timer_en;
    logic   timer_tc;

    // The timer restarts while idle and counts only the cycles that stb is held.
    assign timer_clr = (state_reg == IDLE);
    assign timer_en  = (state_reg == BUS);

    wb_cmd_timer #(
        .MAX (TIMEOUT),
        .W   (TW)
    ) u_timer (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (timer_clr),
        .en    (timer_en),
        .tc    (timer_tc)
    );

    // Handshake outputs decode the state directly and are forced low during reset.
    assign cmd_ready = sys_rst_n && (state_reg == IDLE);
    assign rsp_valid = sys_rst_n && (state_reg == RESP);
    assign wb_sel_o  = WB_SEL_ALL;

    // Sequencer with registered bus and response outputs.
    // The ack is only looked at in BUS, which is the only state with cyc high.
    // A late ack is therefore dropped.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_reg <= IDLE;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        wb_adr_o  <= cmd_adr;
                        wb_dat_o  <= cmd_dat;
                        wb_we_o   <= cmd_we;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        state_reg <= BUS;
                    end
                end
                BUS: begin
                    // The ack is checked first, so an ack in the final allowed cycle still succeeds.
                    if (wb_ack_i) begin
                        rsp_dat   <= wb_we_o ? 32'h0 : wb_dat_i;
                        rsp_err   <= 1'b0;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        state_reg <= RESP;
                    end else if (timer_tc) begin
                        rsp_dat   <= 32'h0;
                        rsp_err   <= 1'b1;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        state_reg <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
